// File: rtl/ifetch_if.sv
// Fetch-stage bus: instruction-memory port, redirect request from execute,
// and the valid/ready hand-off towards decode.
interface ifetch_if #(
  parameter int instrn = 7,
  parameter int ilen   = 32
);
  logic              enable;
  logic [instrn-1:0] imem_addr;
  logic [ilen-1:0]   imem_instr;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              if_valid;
  logic              if_ready;
  logic [ilen-1:0]   if_instr;
  logic [31:0]       if_pc;
  logic              fault;

  modport master (
    input  enable, imem_instr, redirect_valid, redirect_pc, if_ready,
    output imem_addr, if_valid, if_instr, if_pc, fault
  );

  modport slave (
    output enable, imem_instr, redirect_valid, redirect_pc, if_ready,
    input  imem_addr, if_valid, if_instr, if_pc, fault
  );
endinterface

// File: rtl/ifetch.sv
// Instruction fetch stage: PC register, IDLE/RUN/FAULT control, one-entry
// output register towards decode with stall, flush and misaligned-redirect fault.
module ifetch #(
  parameter int          instrn   = 7,
  parameter int          ilen     = 32,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic     clock,
  input  logic     reset,
  ifetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic            if_valid_q;
  logic [ilen-1:0] if_instr_q;
  logic [31:0]     if_pc_q;
  logic            fault_q;

  logic redir_live;
  logic redir_bad;
  logic redir_ok;
  logic fetch;
  logic drain;

  always_comb begin
    redir_live = bus.redirect_valid && (state_q != FAULT);
    redir_bad  = redir_live && (bus.redirect_pc[1:0] != 2'b00);
    redir_ok   = redir_live && !redir_bad;
    fetch      = (state_q == RUN) && bus.enable && !bus.redirect_valid &&
                 (!if_valid_q || bus.if_ready);
    drain      = if_valid_q && bus.if_ready && !fetch;
    pc_d       = pc_q + 32'd4;
  end

  // A redirect freezes the state; a misaligned one traps in FAULT until reset.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.enable && !bus.redirect_valid) state_d = RUN;
      RUN:     if (!bus.enable && !bus.redirect_valid) state_d = IDLE;
      FAULT:   state_d = FAULT;
      default: state_d = IDLE;
    endcase
    if (redir_bad) state_d = FAULT;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      if_valid_q <= 1'b0;
      if_instr_q <= '0;
      if_pc_q    <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (redir_bad) begin
        if_valid_q <= 1'b0;
        fault_q    <= 1'b1;
      end else if (redir_ok) begin
        if_valid_q <= 1'b0;
        pc_q       <= bus.redirect_pc;
      end else if (fetch) begin
        if_valid_q <= 1'b1;
        if_instr_q <= bus.imem_instr;
        if_pc_q    <= pc_q;
        pc_q       <= pc_d;
      end else if (drain) begin
        if_valid_q <= 1'b0;
      end
    end
  end

  // Out-of-range PCs simply alias onto the memory through the truncated index.
  assign bus.imem_addr = pc_q[instrn+1:2];
  assign bus.if_valid  = if_valid_q;
  assign bus.if_instr  = if_instr_q;
  assign bus.if_pc     = if_pc_q;
  assign bus.fault     = fault_q;

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 The block SHALL take parameter instrn, default 7, meaning the instruction memory word-address width (2^instrn words).
REQ-002 The block SHALL take parameter ilen, default 32, meaning the instruction width in bits.
REQ-003 The block SHALL take parameter RESET_PC, default 32'h0000_0000, meaning the byte address loaded into the PC on reset.
REQ-004 clock  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-006 enable  input  1  fetch permission; 1 allows fetching.
REQ-007 imem_addr  output  instrn  word address to the instruction memory, equal to pc[instrn+1:2], combinational from pc.
REQ-008 imem_instr  input  ilen  instruction word returned combinationally by the instruction memory for imem_addr in the same cycle.
REQ-009 redirect_valid  input  1  branch/jump redirect request from execute.
REQ-010 redirect_pc  input  32  redirect target byte address.
REQ-011 if_valid  output  1  if_instr/if_pc hold a valid fetched instruction.
REQ-012 if_ready  input  1  decode accepts the instruction when if_valid and if_ready are both 1.
REQ-013 if_instr  output  ilen  registered fetched instruction.
REQ-014 if_pc  output  32  byte address of if_instr.
REQ-015 fault  output  1  sticky misaligned-redirect indication.

Function
REQ-016 The block SHALL hold a 32-bit pc register and a three-state FSM: IDLE, RUN, FAULT.
REQ-017 IDLE -> RUN on a cycle with enable=1 and redirect_valid=0; no fetch occurs in IDLE.
REQ-018 RUN -> IDLE on a cycle with enable=0; that cycle performs no fetch, but an already-valid if_* entry still completes its handshake.
REQ-019 A fetch SHALL occur in a cycle iff state=RUN, enable=1, redirect_valid=0, and (if_valid=0 or if_ready=1).
REQ-020 On a fetch: if_instr<=imem_instr, if_pc<=pc, if_valid<=1, pc<=pc+4 (modulo 2^32), giving one cycle from pc to if_* outputs.
REQ-021 If if_valid=1, if_ready=1 and no fetch occurs, if_valid SHALL clear to 0 on that edge.
REQ-022 If if_valid=1 and if_ready=0 (stall), pc, if_instr, if_pc and if_valid SHALL hold unchanged.
REQ-023 redirect_valid=1 SHALL take priority over fetch and stall in IDLE and RUN states: if_valid<=0 (flush, regardless of if_ready), pc<=redirect_pc, state unchanged, no fetch that cycle.
REQ-024 If redirect_valid=1 with redirect_pc[1:0]!=2'b00: pc unchanged, if_valid<=0, fault<=1, state<=FAULT.
REQ-025 FAULT SHALL be left only by reset; in FAULT no fetch occurs, if_valid=0, redirect_valid is ignored.
REQ-026 pc values beyond the memory range SHALL wrap via imem_addr=pc[instrn+1:2]; no range error is raised.
REQ-027 if_instr and if_pc SHALL change only on a fetch or reset.

Reset
REQ-028 On reset=1 at a rising edge: pc<=RESET_PC, state<=IDLE, if_valid<=0, if_instr<=0, if_pc<=0, fault<=0, overriding all other inputs including mid-stall or mid-redirect.
REQ-029 imem_addr SHALL equal RESET_PC[instrn+1:2] in the cycle after reset.

Verification
REQ-030 Streaming: reset, enable=1, if_ready=1, memory word k = 32'h1000_0000+k -> from the second cycle after enable, if_pc=0,4,8,... and if_instr=32'h1000_0000,32'h1000_0001,... one per cycle, if_valid continuously 1.
REQ-031 Stall: deassert if_ready for 3 cycles while if_pc=8 -> if_pc=8, if_instr and pc held for 3 cycles; after if_ready=1, next if_pc=12, no instruction skipped or duplicated.
REQ-032 Redirect: redirect_valid=1, redirect_pc=32'h40 while if_valid=1, if_ready=0 -> next cycle if_valid=0; following cycle if_pc=32'h40, if_instr=memory word 16.
REQ-033 Misaligned: redirect_pc=32'h42 -> fault=1, if_valid=0 permanently; further redirects ignored; reset clears fault and restarts at RESET_PC.
REQ-034 Wrap: instrn=7, redirect to 32'h1FC -> fetches word 127 then imem_addr=0 with if_pc=32'h200.
REQ-035 Reset mid-stream: assert reset with if_valid=1, if_ready=0 -> next cycle if_valid=0, pc=RESET_PC, state IDLE, fault=0.
